ula_port: RTL and testbench
===========================

ULA_PORT -- requirements
Module: ula_port

Interface
REQ-001 Parameter AUDIO_BITS, default 8: width of the sigma-delta audio level and accumulator.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth for n_iorq, n_wr, n_rd and ear_in.
REQ-003 clk  in  1  system clock; single clock domain for the whole block.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 addr  in  16  CPU address bus.
REQ-006 cpu_dout  in  8  CPU write data.
REQ-007 n_iorq  in  1  CPU IORQ strobe, active low, asynchronous to clk.
REQ-008 n_wr  in  1  CPU write strobe, active low, asynchronous to clk.
REQ-009 n_rd  in  1  CPU read strobe, active low, asynchronous to clk.
REQ-010 key_data  in  5  keyboard matrix column bits for the current addr[15:8], active low.
REQ-011 ear_in  in  1  tape EAR input, asynchronous to clk.
REQ-012 io_dout  out  8  read data for port 0xFE.
REQ-013 io_oe  out  1  high while a port-0xFE read is in progress; the CPU data mux selects io_dout.
REQ-014 border  out  3  border colour (GRB index), consumed by the video stage.
REQ-015 beeper  out  1  speaker bit.
REQ-016 mic  out  1  MIC/tape-out bit.
REQ-017 audio_pwm  out  1  first-order sigma-delta audio bitstream.

Function
REQ-018 The block SHALL pass n_iorq, n_wr, n_rd and ear_in through SYNC_STAGES flops each before they are used.
REQ-019 Port select SHALL be addr[0]==0 combined with synchronised n_iorq low; addr[15:1] is ignored.
REQ-020 Write detect SHALL be the 1->0 edge of the synchronised (n_iorq|n_wr) while port select is true; exactly one latch per strobe, however long the strobe lasts.
REQ-021 On write detect the block SHALL load border<=cpu_dout[2:0], mic<=cpu_dout[3] and beeper<=cpu_dout[4] on the next clk edge; cpu_dout[7:5] are ignored.
REQ-022 Latency from the raw strobe going low to the outputs updating SHALL be SYNC_STAGES+1 clk cycles.
REQ-023 io_dout SHALL be registered every cycle as {1'b1, ear_sync, 1'b1, key_data}.
REQ-024 io_oe SHALL be registered high while synchronised (n_iorq|n_rd) is low and addr[0]==0, and low otherwise.
REQ-025 If synchronised n_rd and n_wr are both low, the write SHALL take effect and io_oe SHALL be low.
REQ-026 Audio level SHALL be (beeper?0x80:0)+(mic?0x20:0)+(ear_sync?0x10:0), zero-extended to AUDIO_BITS bits; the maximum is 0xB0 and it never overflows.
REQ-027 The accumulator SHALL be AUDIO_BITS+1 bits wide and update each cycle as acc <= {1'b0, acc[AUDIO_BITS-1:0]} + level.
REQ-028 audio_pwm SHALL equal acc[AUDIO_BITS], registered.
REQ-029 The long-run duty of audio_pwm SHALL equal level/2^AUDIO_BITS; the accumulator wraps without saturating.

Reset
REQ-030 While reset is high, border SHALL be 3'b000, beeper and mic SHALL be 0, and io_oe and audio_pwm SHALL be 0.
REQ-031 While reset is high, io_dout SHALL be 8'hFF, the accumulator SHALL be 0, and every synchroniser stage SHALL be 1.
REQ-032 A write strobe in progress when reset is asserted SHALL be discarded.
REQ-033 After reset is released, a strobe that is already low SHALL NOT be detected as a write; a fresh 1->0 edge is required.

Structure
REQ-034 A shared package SHALL hold the constants ULA_PORT_ADDR_BIT=0, BEEPER_WEIGHT=0x80, MIC_WEIGHT=0x20 and EAR_WEIGHT=0x10.
REQ-035 A single sub-module, sync_bit (SYNC_STAGES-deep flop chain with a reset value of 1), SHALL be instantiated once per asynchronous input.

Verification
REQ-036 Bench SHALL check: IO write to 0x00FE with data 0x15, strobe held 20 clk -> border=5, beeper=1, mic=0 after 3 clk; exactly one update.
REQ-037 Bench SHALL check: IO write to 0x00FF with data 0x07 -> border, beeper and mic unchanged.
REQ-038 Bench SHALL check: IO read of 0xFEFE with key_data=5'b11110 and ear_in=1 -> io_oe=1 and io_dout=8'hFE; after the strobe goes high, io_oe=0 within 3 clk.
REQ-039 Bench SHALL check: beeper=1, mic=0, ear=0 over 256 cycles -> exactly 128 ones on audio_pwm; with all bits clear -> 0 ones.
REQ-040 Bench SHALL check: reset pulsed mid-write with the strobe still low -> outputs at their reset values and no latch after release until a new strobe edge.
REQ-041 Bench SHALL check: simultaneous n_rd and n_wr low with data 0x02 -> border=2 and io_oe stays 0.

Source files
------------

// File: rtl/ula_port_pkg.sv
// Shared constants, port-0xFE latch layout and audio level helper for the ULA I/O port.
package ula_port_pkg;

  localparam int         ULA_PORT_ADDR_BIT = 0;
  localparam logic [7:0] BEEPER_WEIGHT     = 8'h80;
  localparam logic [7:0] MIC_WEIGHT        = 8'h20;
  localparam logic [7:0] EAR_WEIGHT        = 8'h10;
  localparam logic [7:0] IO_DOUT_IDLE      = 8'hFF;

  // Field order matches cpu_dout[4:0] so a write is a direct cast.
  typedef struct packed {
    logic       beeper;
    logic       mic;
    logic [2:0] border;
  } port_fe_t;

  localparam port_fe_t PORT_FE_RESET = '{beeper: 1'b0, mic: 1'b0, border: 3'b000};

  // Weighted sum of the three sound sources; tops out at 0xB0, so no carry out.
  function automatic logic [7:0] audio_level(input logic beeper,
                                             input logic mic,
                                             input logic ear);
    logic [7:0] v_sum;
    v_sum = (beeper ? BEEPER_WEIGHT : 8'h00)
          + (mic    ? MIC_WEIGHT    : 8'h00)
          + (ear    ? EAR_WEIGHT    : 8'h00);
    return v_sum;
  endfunction

endpackage

// File: rtl/ula_port_sync_bit.sv
// Multi-flop synchroniser for one asynchronous bit; idles high so active-low strobes read inactive in reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw input through the chain, forcing every stage high in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= {STAGES{1'b1}};
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/ula_port.sv
// ULA port 0xFE: border/MIC/beeper latch, keyboard/EAR read-back and a first-order sigma-delta audio output.
module ula_port
  import ula_port_pkg::*;
#(
  parameter int AUDIO_BITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  cpu_dout,
  input  logic        n_iorq,
  input  logic        n_wr,
  input  logic        n_rd,
  input  logic [4:0]  key_data,
  input  logic        ear_in,
  output logic [7:0]  io_dout,
  output logic        io_oe,
  output logic [2:0]  border,
  output logic        beeper,
  output logic        mic,
  output logic        audio_pwm
);

  localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

  logic w_iorq_s;
  logic w_wr_s;
  logic w_rd_s;
  logic w_ear_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_iorq (.clk(clk), .reset(reset), .i_d(n_iorq), .o_q(w_iorq_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_wr   (.clk(clk), .reset(reset), .i_d(n_wr),   .o_q(w_wr_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rd   (.clk(clk), .reset(reset), .i_d(n_rd),   .o_q(w_rd_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ear  (.clk(clk), .reset(reset), .i_d(ear_in), .o_q(w_ear_s));

  logic w_port_sel;
  logic w_wr_strobe;
  logic w_wr_detect;
  logic w_rd_active;
  logic w_unused_bits;

  assign w_port_sel  = ~addr[ULA_PORT_ADDR_BIT] & ~w_iorq_s;
  assign w_wr_strobe = w_iorq_s | w_wr_s;
  assign w_rd_active = w_port_sel & ~w_rd_s & w_wr_s;
  assign w_unused_bits = ^{addr[15:1], cpu_dout[7:5]};

  logic                r_wr_prev;
  logic [FILL_W-1:0]   r_fill;
  port_fe_t            r_port;
  logic                r_io_oe;
  logic [7:0]          r_io_dout;
  logic [AUDIO_BITS:0] r_acc;
  logic                r_pwm;

  assign w_wr_detect = r_wr_prev & ~w_wr_strobe & w_port_sel;

  // Edge history stays disarmed until the synchronisers hold post-reset samples,
  // so a strobe already low at reset release never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill    <= {FILL_W{1'b0}};
      r_wr_prev <= 1'b0;
    end else if (r_fill == FILL_DONE) begin
      r_fill    <= r_fill;
      r_wr_prev <= w_wr_strobe;
    end else begin
      r_fill    <= r_fill + FILL_W'(1);
      r_wr_prev <= 1'b0;
    end
  end

  // Port 0xFE output latch, loaded once per write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_port <= PORT_FE_RESET;
    end else if (w_wr_detect) begin
      r_port <= port_fe_t'(cpu_dout[4:0]);
    end else begin
      r_port <= r_port;
    end
  end

  // Read path; a write occurring at the same time wins, so the data mux stays off.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_io_oe   <= 1'b0;
      r_io_dout <= IO_DOUT_IDLE;
    end else begin
      r_io_oe   <= w_rd_active;
      r_io_dout <= {1'b1, w_ear_s, 1'b1, key_data};
    end
  end

  logic [7:0]            w_level_byte;
  logic [AUDIO_BITS-1:0] w_level;

  assign w_level_byte = audio_level(r_port.beeper, r_port.mic, w_ear_s);
  assign w_level      = AUDIO_BITS'(w_level_byte);

  // Sigma-delta modulator: the carry out of the wrapping accumulator is the bitstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= {(AUDIO_BITS + 1){1'b0}};
      r_pwm <= 1'b0;
    end else begin
      r_acc <= {1'b0, r_acc[AUDIO_BITS-1:0]} + {1'b0, w_level};
      r_pwm <= r_acc[AUDIO_BITS];
    end
  end

  assign io_dout   = r_io_dout;
  assign io_oe     = r_io_oe;
  assign border    = r_port.border;
  assign beeper    = r_port.beeper;
  assign mic       = r_port.mic;
  assign audio_pwm = r_pwm;

endmodule

// File: tb/tb_ula_port.sv
// Bench for ula_port: cycle model of the port behaviour plus directed literal checks.
module tb_ula_port;

  localparam int S    = 2;
  localparam int AB   = 8;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  cpu_dout;
  logic        n_iorq, n_wr, n_rd;
  logic [4:0]  key_data;
  logic        ear_in;
  logic [7:0]  io_dout;
  logic        io_oe;
  logic [2:0]  border;
  logic        beeper, mic, audio_pwm;

  ula_port #(.AUDIO_BITS(AB), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .addr(addr), .cpu_dout(cpu_dout),
    .n_iorq(n_iorq), .n_wr(n_wr), .n_rd(n_rd), .key_data(key_data), .ear_in(ear_in),
    .io_dout(io_dout), .io_oe(io_oe), .border(border), .beeper(beeper),
    .mic(mic), .audio_pwm(audio_pwm)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raw input history, one entry per rising edge.
  bit h_rst [MAXC];
  bit h_iorq[MAXC];
  bit h_wr  [MAXC];
  bit h_rd  [MAXC];
  bit h_ear [MAXC];
  int cyc = 0;

  // What the block sees of a raw input after edge k: the sample taken S-1 edges
  // earlier, or idle-high if reset touched any of the last S edges.
  function automatic bit vsig(input int sel, input int k);
    if (k - S + 1 < 0) return 1'b1;
    for (int j = k - S + 1; j <= k; j++) if (h_rst[j]) return 1'b1;
    case (sel)
      0:       return h_iorq[k-S+1];
      1:       return h_wr[k-S+1];
      2:       return h_rd[k-S+1];
      3:       return h_ear[k-S+1];
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit genuine(input int k);
    if (k - S + 1 < 0) return 1'b0;
    for (int j = k - S + 1; j <= k; j++) if (h_rst[j]) return 1'b0;
    return 1'b1;
  endfunction

  logic [2:0] m_border;
  logic       m_beeper, m_mic, m_oe, m_pwm;
  logic [7:0] m_dout;
  int         m_acc;

  initial begin
    forever begin
      @(posedge clk);
      begin
        int k;
        int lvl;
        bit wn, wp;
        k = cyc;
        h_rst[k] = reset; h_iorq[k] = n_iorq; h_wr[k] = n_wr; h_rd[k] = n_rd; h_ear[k] = ear_in;
        if (reset) begin
          m_border = 3'd0; m_beeper = 1'b0; m_mic = 1'b0;
          m_oe = 1'b0; m_dout = 8'hFF; m_pwm = 1'b0; m_acc = 0;
        end else begin
          lvl   = (m_beeper ? 128 : 0) + (m_mic ? 32 : 0) + (vsig(3, k-1) ? 16 : 0);
          m_pwm = (m_acc >= 256);
          m_acc = (m_acc % 256) + lvl;
          wn = vsig(0, k-1) | vsig(1, k-1);
          wp = vsig(0, k-2) | vsig(1, k-2);
          if (!addr[0] && !wn && wp && genuine(k-2)) begin
            m_border = cpu_dout[2:0];
            m_mic    = cpu_dout[3];
            m_beeper = cpu_dout[4];
          end
          m_oe   = !addr[0] && !vsig(0, k-1) && !vsig(2, k-1) && vsig(1, k-1);
          m_dout = {1'b1, vsig(3, k-1), 1'b1, key_data};
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("model_border",  32'(border),    32'(m_border));
        check("model_beeper",  32'(beeper),    32'(m_beeper));
        check("model_mic",     32'(mic),       32'(m_mic));
        check("model_io_oe",   32'(io_oe),     32'(m_oe));
        check("model_io_dout", 32'(io_dout),   32'(m_dout));
        check("model_pwm",     32'(audio_pwm), 32'(m_pwm));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    addr = a; cpu_dout = d; n_iorq = 1'b0; n_wr = 1'b0;
    step(hold);
    n_iorq = 1'b1; n_wr = 1'b1;
    step(4);
  endtask

  task automatic count_ones(output int ones);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      if (audio_pwm) ones++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] snap, prev;
    int chg, ones, w;

    reset = 1'b1; addr = 16'hFFFF; cpu_dout = 8'h00;
    n_iorq = 1'b1; n_wr = 1'b1; n_rd = 1'b1; key_data = 5'h1F; ear_in = 1'b1;
    step(4);
    check("rst_border", 32'(border),    32'd0);
    check("rst_beeper", 32'(beeper),    32'd0);
    check("rst_mic",    32'(mic),       32'd0);
    check("rst_io_oe",  32'(io_oe),     32'd0);
    check("rst_pwm",    32'(audio_pwm), 32'd0);
    check("rst_io_dout",32'(io_dout),   32'hFF);
    reset = 1'b0;
    step(4);

    // Long write: one latch after three clocks, later data changes ignored.
    addr = 16'h00FE; cpu_dout = 8'h15; n_iorq = 1'b0; n_wr = 1'b0;
    prev = {beeper, mic, border};
    chg = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      snap = {beeper, mic, border};
      if (snap != prev) chg++;
      prev = snap;
      if (i == 1) check("wr_latency_early", 32'(border), 32'd0);
      if (i == 2) begin
        check("wr_border", 32'(border), 32'd5);
        check("wr_beeper", 32'(beeper), 32'd1);
        check("wr_mic",    32'(mic),    32'd0);
        cpu_dout = 8'h02;
      end
    end
    check("wr_single_update", 32'(chg), 32'd1);
    n_iorq = 1'b1; n_wr = 1'b1;
    step(4);
    check("wr_hold_border", 32'(border), 32'd5);

    // Odd address is not port 0xFE.
    io_write(16'h00FF, 8'h07, 5);
    check("odd_border", 32'(border), 32'd5);
    check("odd_beeper", 32'(beeper), 32'd1);
    check("odd_mic",    32'(mic),    32'd0);

    // Keyboard read.
    addr = 16'hFEFE; key_data = 5'b11110; ear_in = 1'b1; n_iorq = 1'b0; n_rd = 1'b0;
    step(4);
    check("rd_io_oe",   32'(io_oe),   32'd1);
    check("rd_io_dout", 32'(io_dout), 32'hFE);
    n_iorq = 1'b1; n_rd = 1'b1;
    w = 0;
    while (io_oe !== 1'b0 && w < 3) begin
      step(1);
      w++;
    end
    check("rd_oe_release", 32'(io_oe), 32'd0);

    // Audio duty: beeper only, then silence.
    addr = 16'hFFFF; key_data = 5'h1F; ear_in = 1'b0;
    step(8);
    count_ones(ones);
    check("pwm_beeper_ones", 32'(ones), 32'd128);
    io_write(16'h00FE, 8'h00, 3);
    step(8);
    count_ones(ones);
    check("pwm_silent_ones", 32'(ones), 32'd0);

    // Reset in the middle of a write, strobe still low afterwards.
    addr = 16'h00FE; cpu_dout = 8'h0C; n_iorq = 1'b0; n_wr = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
    check("midrst_border", 32'(border),    32'd0);
    check("midrst_mic",    32'(mic),       32'd0);
    check("midrst_beeper", 32'(beeper),    32'd0);
    check("midrst_io_oe",  32'(io_oe),     32'd0);
    check("midrst_pwm",    32'(audio_pwm), 32'd0);
    check("midrst_io_dout",32'(io_dout),   32'hFF);
    reset = 1'b0;
    step(10);
    check("norelatch_border", 32'(border), 32'd0);
    check("norelatch_mic",    32'(mic),    32'd0);
    n_iorq = 1'b1; n_wr = 1'b1;
    step(4);
    n_iorq = 1'b0; n_wr = 1'b0;
    step(3);
    check("fresh_edge_border", 32'(border), 32'd4);
    check("fresh_edge_mic",    32'(mic),    32'd1);
    n_iorq = 1'b1; n_wr = 1'b1;
    step(4);

    // Read and write strobes together: write wins, data mux stays off.
    addr = 16'h00FE; cpu_dout = 8'h02; n_iorq = 1'b0; n_wr = 1'b0; n_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("rdwr_io_oe", 32'(io_oe), 32'd0);
    end
    check("rdwr_border", 32'(border), 32'd2);
    n_iorq = 1'b1; n_wr = 1'b1; n_rd = 1'b1;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
